// File: rtl/hack_soc_pkg.sv
// Shared definitions for the Hack SoC: top-level state encoding and default memory-mapped I/O addresses.
// No logic, no latency.
package hack_soc_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [14:0] KBD_ADDR_DEF  = 15'h6000;
  localparam logic [14:0] OUT_ADDR_DEF  = 15'h6001;
  localparam logic [14:0] HALT_ADDR_DEF = 15'h6002;

endpackage

// File: rtl/cpu.sv
// Hack CPU: A/D registers, ALU and PC. One instruction per cycle; memory reads via in_m are combinational.
// No backpressure; reset (active-high, synchronous) holds pc at 0, rst_n clears all registers asynchronously.
module cpu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reset,
  input  logic [15:0] in_m,
  input  logic [15:0] instruction,
  output logic [15:0] out_m,
  output logic        write_m,
  output logic [14:0] address_m,
  output logic [15:0] pc
);

  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] alu;
  logic        is_c;
  logic        zr;
  logic        ng;
  logic        jump;
  logic        unused_bits;

  assign unused_bits = ^instruction[14:13];

  always_comb begin
    is_c = instruction[15];
    x    = d_reg;
    y    = instruction[12] ? in_m : a_reg;
    if (instruction[11]) x = 16'h0000;
    if (instruction[10]) x = ~x;
    if (instruction[9])  y = 16'h0000;
    if (instruction[8])  y = ~y;
    alu = instruction[7] ? (x + y) : (x & y);
    if (instruction[6]) alu = ~alu;
    zr   = (alu == 16'h0000);
    ng   = alu[15];
    jump = is_c & ((instruction[2] & ng) | (instruction[1] & zr) | (instruction[0] & ~ng & ~zr));
  end

  assign out_m     = alu;
  assign write_m   = is_c & instruction[3];
  assign address_m = a_reg[14:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= 16'h0000;
      d_reg <= 16'h0000;
      pc    <= 16'h0000;
    end else begin
      if (!is_c)               a_reg <= instruction;
      else if (instruction[5]) a_reg <= alu;
      if (is_c && instruction[4]) d_reg <= alu;
      if (reset)     pc <= 16'h0000;
      else if (jump) pc <= a_reg;
      else           pc <= pc + 16'h0001;
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO; head is visible on out_dat the cycle after the push (fall-through read of registered storage).
// in_rdy drops when full unless the head is popped in the same cycle; clr empties it synchronously.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             push;
  logic             pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_vld = (wr_ptr != rd_ptr);
  assign out_dat = mem[rd_ptr[AW-1:0]];
  assign pop     = out_vld & out_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the word.
  assign in_rdy  = !full || out_rdy;
  assign push    = in_vld & in_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr[AW-1:0]] <= in_dat;
  end

endmodule

// File: rtl/hack_soc.sv
// Hack SoC: program loader, ROM, data RAM, keyboard/out/halt I/O and output FIFO; HACK_SOC_CYCLE_COUNTER_EN adds the RUN-cycle counter.
// Fetch and loads are combinational; out stream is backpressured by out_ready, CPU writes into a full FIFO are dropped and flagged on out_ovf.
module hack_soc
  import hack_soc_pkg::*;
#(
  parameter int          ROM_AW    = 15,
  parameter int          RAM_AW    = 6,
  parameter int          OUT_DEPTH = 4,
  parameter logic [14:0] KBD_ADDR  = KBD_ADDR_DEF,
  parameter logic [14:0] OUT_ADDR  = OUT_ADDR_DEF,
  parameter logic [14:0] HALT_ADDR = HALT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_valid,
  output logic        prog_ready,
  input  logic        prog_last,
  input  logic [15:0] prog_data,
  input  logic        run,
  input  logic [15:0] key_in,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  state_out,
  output logic [15:0] pc_out,
  output logic        out_ovf,
  output logic [31:0] cycles
);

  localparam int ROM_DEPTH = 1 << ROM_AW;
  localparam int RAM_DEPTH = 1 << RAM_AW;

  state_t        state;
  state_t        state_nxt;
  logic [ROM_AW:0] wptr;
  logic [15:0]   rom [ROM_DEPTH];
  logic [15:0]   ram [RAM_DEPTH];
  logic [15:0]   instruction;
  logic [15:0]   in_m;
  logic [15:0]   out_m;
  logic [15:0]   pc;
  logic [14:0]   address_m;
  logic          write_m;
  logic          running;
  logic          prog_acc;
  logic          load_entry;
  logic          ram_sel;
  logic          halt_wr;
  logic          out_push;
  logic          fifo_in_rdy;
  logic          rom_we;

  assign running    = (state == ST_RUN);
  assign prog_ready = (state == ST_LOAD) || (state == ST_HALT);
  assign prog_acc   = prog_valid & prog_ready;
  assign ram_sel    = (address_m < 15'(RAM_DEPTH));
  assign halt_wr    = running & write_m & (address_m == HALT_ADDR);
  assign out_push   = running & write_m & (address_m == OUT_ADDR);
  assign state_out  = state;
  assign pc_out     = pc;

  always_comb begin
    state_nxt  = state;
    load_entry = 1'b0;
    case (state)
      ST_LOAD: if (prog_acc && prog_last) state_nxt = ST_RUN;
      ST_RUN:  if (halt_wr) state_nxt = ST_HALT;
      ST_HALT: begin
        if (prog_valid) begin
          load_entry = 1'b1;
          state_nxt  = ST_LOAD;
        end else if (run) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_LOAD;
      wptr    <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      // The beat that pulls HALT back into LOAD is word 0 of the new image.
      if (load_entry)
        wptr <= (ROM_AW+1)'(1);
      else if (state == ST_LOAD && prog_acc && !wptr[ROM_AW])
        wptr <= wptr + 1'b1;
      if (load_entry)
        out_ovf <= 1'b0;
      else if (out_push && !fifo_in_rdy)
        out_ovf <= 1'b1;
    end
  end

  assign rom_we = prog_acc && ((state == ST_HALT) || !wptr[ROM_AW]);

  always_ff @(posedge clk) begin
    if (rom_we) rom[(state == ST_HALT) ? '0 : wptr[ROM_AW-1:0]] <= prog_data;
  end

  // Writes are qualified by RUN, which reset forces away asynchronously, so an aborted cycle never lands.
  always_ff @(posedge clk) begin
    if (running && write_m && ram_sel) ram[address_m[RAM_AW-1:0]] <= out_m;
  end

  assign instruction = rom[pc[ROM_AW-1:0]];

  always_comb begin
    in_m = 16'h0000;
    if (ram_sel)                     in_m = ram[address_m[RAM_AW-1:0]];
    else if (address_m == KBD_ADDR)  in_m = key_in;
  end

  cpu u_cpu (
    .clk         (clk),
    .rst_n       (reset),
    .reset       (!running),
    .in_m        (in_m),
    .instruction (instruction),
    .out_m       (out_m),
    .write_m     (write_m),
    .address_m   (address_m),
    .pc          (pc)
  );

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (load_entry),
    .in_vld  (out_push),
    .in_rdy  (fifo_in_rdy),
    .in_dat  (out_m),
    .out_vld (out_valid),
    .out_rdy (out_ready),
    .out_dat (out_data)
  );

`ifdef HACK_SOC_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          cycle_cnt <= 32'd0;
    else if (load_entry) cycle_cnt <= 32'd0;
    else if (running)    cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign cycles = cycle_cnt;
`else
  assign cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hack_soc.sv
// Bench for hack_soc: scenario tasks drive programs through the loader, a scoreboard tracks the output stream.
module tb_hack_soc;

  localparam int ROM_AW = 4;
`ifdef HACK_SOC_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        prog_valid = 1'b0;
  logic        prog_last = 1'b0;
  logic [15:0] prog_data = 16'h0000;
  logic        run = 1'b0;
  logic [15:0] key_in = 16'h0000;
  logic        out_ready = 1'b0;
  logic        prog_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic [1:0]  state_out;
  logic [15:0] pc_out;
  logic        out_ovf;
  logic [31:0] cycles;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] sb [$];
  logic [15:0] prog [$];
  logic [15:0] exp_w;

  hack_soc #(
    .ROM_AW    (ROM_AW),
    .RAM_AW    (6),
    .OUT_DEPTH (4),
    .KBD_ADDR  (15'h6000),
    .OUT_ADDR  (15'h6001),
    .HALT_ADDR (15'h6002)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_last  (prog_last),
    .prog_data  (prog_data),
    .run        (run),
    .key_in     (key_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .state_out  (state_out),
    .pc_out     (pc_out),
    .out_ovf    (out_ovf),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  // Output monitor: every accepted word must match the oldest expected one.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL fifo_unexpected: got %h, nothing expected", out_data);
      end else begin
        exp_w = sb.pop_front();
        if (out_data !== exp_w) begin
          n_fail++;
          $display("FAIL fifo_data: got %h expected %h", out_data, exp_w);
        end
      end
    end
  end

  task automatic load_prog(input int first);
    for (int i = first; i < prog.size(); i++) begin
      prog_valid = 1'b1;
      prog_data  = prog[i];
      prog_last  = (i == prog.size() - 1);
      @(posedge clk); #1;
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int i = 0;
    while (state_out !== 2'b10 && i < 500) begin
      @(posedge clk); #1;
      i++;
    end
    n_chk++;
    if (state_out !== 2'b10) begin n_fail++; $display("FAIL %s_halt: state %b expected 10", tag, state_out); end
  endtask

  task automatic drain(input string tag);
    int i = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: out_valid %b with %0d words outstanding, expected 0/0", tag, out_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (state_out !== 2'b00) begin n_fail++; $display("FAIL rst_state: got %b expected 00", state_out); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", out_ovf); end
    n_chk++; if (cycles !== 32'd0) begin n_fail++; $display("FAIL rst_cycles: got %0d expected 0", cycles); end
    n_chk++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h expected 0000", pc_out); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (prog_ready !== 1'b1) begin n_fail++; $display("FAIL rst_prog_ready: got %b expected 1", prog_ready); end
    n_chk++; if (state_out !== 2'b00) begin n_fail++; $display("FAIL rst_release_state: got %b expected 00", state_out); end
  endtask

  task automatic test_load_run();
    prog = '{16'h6002, 16'hEA88, 16'h0000};
    load_prog(0);
    n_chk++; if (state_out !== 2'b01) begin n_fail++; $display("FAIL load_run_state: got %b expected 01", state_out); end
    n_chk++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL load_run_pc: got %h expected 0000", pc_out); end
    wait_halt("load_run");
    n_chk++; if (cycles !== (CNT_EN ? 32'd2 : 32'd0)) begin n_fail++; $display("FAIL load_run_cycles: got %0d expected %0d", cycles, CNT_EN ? 2 : 0); end
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (cycles !== (CNT_EN ? 32'd2 : 32'd0)) begin n_fail++; $display("FAIL halt_cycles_hold: got %0d expected %0d", cycles, CNT_EN ? 2 : 0); end
  endtask

  task automatic test_out_basic();
    prog = '{16'h0005, 16'hEC10, 16'h6001, 16'hE308, 16'h6002, 16'hEA88};
    sb.push_back(16'h0005);
    load_prog(0);
    n_chk++; if (state_out !== 2'b01 || pc_out !== 16'h0000) begin n_fail++; $display("FAIL out_basic_start: state %b pc %h expected 01 0000", state_out, pc_out); end
    wait_halt("out_basic");
    n_chk++; if (out_valid !== 1'b1 || out_data !== 16'h0005) begin n_fail++; $display("FAIL out_basic_head: valid %b data %h expected 1 0005", out_valid, out_data); end
    n_chk++; if (cycles !== (CNT_EN ? 32'd6 : 32'd0)) begin n_fail++; $display("FAIL out_basic_cycles: got %0d expected %0d", cycles, CNT_EN ? 6 : 0); end
    drain("out_basic");
  endtask

  task automatic test_back_to_back();
    prog = '{16'h6001, 16'hEFD8, 16'hE7D8, 16'hE7D8, 16'hE7D8, 16'hE7D8, 16'h6002, 16'hEA88};
    for (int k = 1; k <= 5; k++) sb.push_back(16'(k));
    load_prog(0);
    repeat (5) @(posedge clk);
    #1;
    n_chk++; if (out_data !== 16'h0001) begin n_fail++; $display("FAIL b2b_full_head: got %h expected 0001", out_data); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_halt("b2b");
    n_chk++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b expected 0", out_ovf); end
    n_chk++; if (out_data !== 16'h0002) begin n_fail++; $display("FAIL b2b_head: got %h expected 0002", out_data); end
    drain("b2b");
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 4; k++) sb.push_back(16'(k));
    load_prog(0);
    wait_halt("ovf");
    n_chk++; if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", out_ovf); end
    n_chk++; if (out_valid !== 1'b1 || out_data !== 16'h0001) begin n_fail++; $display("FAIL ovf_head: valid %b data %h expected 1 0001", out_valid, out_data); end
  endtask

  task automatic test_halt_resume();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_chk++; if (out_data !== 16'h0003) begin n_fail++; $display("FAIL resume_pre_head: got %h expected 0003", out_data); end
    sb.push_back(16'h0001);
    sb.push_back(16'h0002);
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    n_chk++; if (state_out !== 2'b01) begin n_fail++; $display("FAIL resume_state: got %b expected 01", state_out); end
    n_chk++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL resume_pc: got %h expected 0000", pc_out); end
    n_chk++; if (out_valid !== 1'b1 || out_data !== 16'h0003) begin n_fail++; $display("FAIL resume_fifo_kept: valid %b data %h expected 1 0003", out_valid, out_data); end
    wait_halt("resume");
    n_chk++; if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL resume_ovf: got %b expected 1", out_ovf); end
    drain("resume");
  endtask

  task automatic test_kbd_priority();
    prog = '{16'h6000, 16'hFC10, 16'h0002, 16'hE308, 16'hEA90, 16'hFC10, 16'h6001, 16'hE308,
             16'h6002, 16'hEA88, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
             16'h6002, 16'hEA88};
    key_in = 16'hABCD;
    sb.push_back(16'hABCD);
    prog_valid = 1'b1;
    prog_data  = prog[0];
    run        = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    n_chk++; if (state_out !== 2'b00) begin n_fail++; $display("FAIL prio_state: got %b expected 00", state_out); end
    n_chk++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL prio_ovf_clear: got %b expected 0", out_ovf); end
    n_chk++; if (cycles !== 32'd0) begin n_fail++; $display("FAIL prio_cycles_clear: got %0d expected 0", cycles); end
    for (int i = 1; i < prog.size(); i++) begin
      prog_valid = 1'b1;
      prog_data  = prog[i];
      prog_last  = (i == prog.size() - 1);
      if (i >= 16) begin
        n_chk++;
        if (prog_ready !== 1'b1) begin n_fail++; $display("FAIL sat_prog_ready_%0d: got %b expected 1", i, prog_ready); end
      end
      @(posedge clk); #1;
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    n_chk++; if (state_out !== 2'b01) begin n_fail++; $display("FAIL kbd_run_state: got %b expected 01", state_out); end
    wait_halt("kbd");
    n_chk++; if (out_valid !== 1'b1 || out_data !== 16'hABCD) begin n_fail++; $display("FAIL kbd_ram2: valid %b data %h expected 1 abcd", out_valid, out_data); end
    drain("kbd");
  endtask

  task automatic test_reset_mid_run();
    prog = '{16'h6001, 16'hE7D8, 16'h0000, 16'hEA87};
    load_prog(0);
    repeat (30) @(posedge clk);
    #1;
    n_chk++; if (state_out !== 2'b01 || out_ovf !== 1'b1) begin n_fail++; $display("FAIL loop_pre_reset: state %b ovf %b expected 01 1", state_out, out_ovf); end
    n_chk++; if (cycles !== (CNT_EN ? 32'd30 : 32'd0)) begin n_fail++; $display("FAIL loop_cycles: got %0d expected %0d", cycles, CNT_EN ? 30 : 0); end
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    n_chk++; if (state_out !== 2'b00) begin n_fail++; $display("FAIL midrst_state: got %b expected 00", state_out); end
    n_chk++; if (out_valid !== 1'b0 || out_ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_fifo: valid %b ovf %b expected 0 0", out_valid, out_ovf); end
    n_chk++; if (cycles !== 32'd0 || pc_out !== 16'h0000) begin n_fail++; $display("FAIL midrst_cnt_pc: cycles %0d pc %h expected 0 0000", cycles, pc_out); end
    n_chk++; if (prog_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_prog_ready: got %b expected 1", prog_ready); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (state_out !== 2'b00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: state %b valid %b expected 00 0", state_out, out_valid); end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_out_basic();
    test_back_to_back();
    test_overflow();
    test_halt_resume();
    test_kbd_priority();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_soc.md
HACK_SOC -- requirements
Module: hack_soc

Interface
REQ-001 SHALL have parameter ROM_AW, default 15, ROM address width (depth 2^ROM_AW words, 1..15).
REQ-002 SHALL have parameter RAM_AW, default 6, data-RAM address width (depth 2^RAM_AW words, 1..14).
REQ-003 SHALL have parameter OUT_DEPTH, default 4, output-FIFO depth in words (power of 2, >=2).
REQ-004 SHALL have parameters KBD_ADDR 15'h6000, OUT_ADDR 15'h6001 and HALT_ADDR 15'h6002, the memory-mapped I/O addresses.
REQ-005 SHALL have port clk, input, 1, the single clock for all state.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-007 SHALL have prog_valid/prog_ready/prog_last, in/out/in, 1 each, the program-load handshake.
REQ-008 SHALL have prog_data, input, 16, the ROM word being loaded.
REQ-009 SHALL have run, input, 1, which restarts execution from HALT.
REQ-010 SHALL have key_in, input, 16, the value read at KBD_ADDR.
REQ-011 SHALL have out_data/out_valid/out_ready, out/out/in, 16/1/1, the output-FIFO stream.
REQ-012 SHALL have state_out, output, 2 (00 LOAD, 01 RUN, 10 HALT), and pc_out, output, 16, the current fetch address.
REQ-013 SHALL have out_ovf, output, 1, sticky, set when a CPU write to a full FIFO is dropped.
REQ-014 SHALL have cycles, output, 32, the RUN-cycle count (see Configuration).

Function
REQ-015 SHALL use FSM LOAD->RUN->HALT; LOAD->RUN when a beat with prog_last is accepted; RUN->HALT on a CPU write to HALT_ADDR; HALT->RUN when run=1; HALT->LOAD when prog_valid=1; if both are 1, LOAD wins.
REQ-016 SHALL assert prog_ready only in LOAD (and HALT for the entry beat); each accepted beat writes rom[wptr] and increments wptr; entry to LOAD clears wptr to 0.
REQ-017 SHALL discard beats with wptr >= 2^ROM_AW, with wptr saturating there and prog_ready staying 1.
REQ-018 SHALL hold the cpu reset input high in every state except RUN, so the first RUN cycle fetches address 0.
REQ-019 SHALL give the instruction as a combinational ROM read at pc truncated to ROM_AW bits, with pc_out equal to the cpu pc.
REQ-020 SHALL decode: addressM < 2^RAM_AW -> RAM (combinational read, write on clk edge when writeM); KBD_ADDR -> reads key_in; every other address -> reads 16'h0000.
REQ-021 SHALL push outM into the FIFO on a write to OUT_ADDR in RUN; when the FIFO is full the word is dropped and out_ovf is set; write to KBD_ADDR and to unmapped addresses SHALL be ignored.
REQ-022 SHALL present the FIFO head on out_data with out_valid=!empty, popping on out_valid&out_ready; a simultaneous push and pop on a full FIFO SHALL succeed without overflow.
REQ-023 SHALL keep FIFO contents and RAM across HALT->RUN, and SHALL clear the FIFO and out_ovf on entry to LOAD.

Reset
REQ-024 SHALL, on reset low: state LOAD, wptr 0, FIFO empty, out_valid 0, out_ovf 0, cycles 0, prog_ready 1 after release; ROM and RAM contents are not reset.
REQ-025 SHALL, when reset is asserted mid-RUN, abort immediately and discard any in-flight write.

Configuration
REQ-026 SHALL, with macro HACK_SOC_CYCLE_COUNTER_EN defined, increment cycles every RUN cycle, wrap at 2^32, hold it in HALT, and clear it on LOAD entry; without the macro, cycles SHALL be a constant 0 with no counter flops.

Structure
REQ-027 SHALL place the state encoding and default I/O addresses in shared package hack_soc_pkg.
REQ-028 SHALL instantiate the existing cpu unchanged and implement the output FIFO as sub-module sync_fifo (parametrised width/depth).

Verification
REQ-029 SHALL cover: load 3 words ending with prog_last -> state RUN next cycle, pc_out=0.
REQ-030 SHALL cover: program @5;D=A;@OUT_ADDR;M=D;@HALT_ADDR;M=0 -> out_data=16'h0005 with out_valid=1, then state HALT.
REQ-031 SHALL cover: out_ready=0 with OUT_DEPTH+1 writes of 1..5 -> FIFO holds 1..4, out_ovf=1.
REQ-032 SHALL cover: key_in=16'hABCD, program copies KBD_ADDR into RAM[2] -> RAM[2]=16'hABCD.
REQ-033 SHALL cover: run=1 in HALT -> pc_out=0 next RUN cycle, FIFO preserved; prog_valid=1 and run=1 together -> LOAD.
REQ-034 SHALL cover: reset low mid-RUN -> all outputs return to reset values, and with HACK_SOC_CYCLE_COUNTER_EN cycles=0.
